// File: rtl/dbus_responder_pkg.sv
// Shared constants for the data-bus responder: I/O register offsets and
// STATUS register bit positions.
package dbus_responder_pkg;

  localparam logic [1:0] IO_CYCLE  = 2'd0;
  localparam logic [1:0] IO_TXDATA = 2'd1;
  localparam logic [1:0] IO_STATUS = 2'd2;
  localparam logic [1:0] IO_INPORT = 2'd3;

  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_OVF   = 2;

endpackage

// File: rtl/dbus_fifo.sv
// Small synchronous FIFO with registered head (no fall-through). A push while
// full is accepted only when a pop happens in the same cycle.
module dbus_fifo #(
  parameter int width           = 16,
  parameter int fifo_depth_log2 = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [width-1:0] push_data,
  input  logic             pop,
  output logic [width-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int depth = 1 << fifo_depth_log2;

  logic [width-1:0]           mem [depth];
  logic [fifo_depth_log2-1:0] wr_ptr;
  logic [fifo_depth_log2-1:0] rd_ptr;
  logic [fifo_depth_log2:0]   count;
  logic                       do_push;
  logic                       do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (fifo_depth_log2 + 1)'(depth));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{fifo_depth_log2{1'b0}}, do_push}
                     - {{fifo_depth_log2{1'b0}}, do_pop};
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/dbus_responder.sv
// CPU data-bus responder: word RAM in the low half of the address space and a
// small I/O block (cycle counter, TX FIFO, status, input port) in the high half.
module dbus_responder
  import dbus_responder_pkg::*;
#(
  parameter int width           = 16,
  parameter int daddr_width     = 8,
  parameter int fifo_depth_log2 = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [daddr_width-1:0] daddr,
  input  logic                   dwrite,
  input  logic [width-1:0]       dD,
  output logic [width-1:0]       dQ,
  output logic [width-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  input  logic [width-1:0]       in_port
);

  localparam int ram_aw = daddr_width - 1;

  logic [width-1:0] ram [2**ram_aw];
  logic [width-1:0] cycle;
  logic [width-1:0] in_port_r;
  logic [width-1:0] rd_val;
  logic [width-1:0] status_word;
  logic             overflow;
  logic             is_io;
  logic [1:0]       io_sel;
  logic             cyc_wr, tx_wr, st_wr;
  logic             pop, drop;
  logic             fifo_empty, fifo_full;

  assign is_io  = daddr[daddr_width-1];
  assign io_sel = daddr[1:0];
  assign cyc_wr = dwrite & is_io & (io_sel == IO_CYCLE);
  assign tx_wr  = dwrite & is_io & (io_sel == IO_TXDATA);
  assign st_wr  = dwrite & is_io & (io_sel == IO_STATUS);

  assign pop       = out_valid & out_ready;
  assign drop      = tx_wr & fifo_full & ~pop;
  assign out_valid = ~fifo_empty;

  dbus_fifo #(
    .width          (width),
    .fifo_depth_log2(fifo_depth_log2)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (tx_wr),
    .push_data(dD),
    .pop      (pop),
    .head     (out_data),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  always_comb begin
    status_word         = '0;
    status_word[ST_FULL]  = fifo_full;
    status_word[ST_EMPTY] = fifo_empty;
    status_word[ST_OVF]   = overflow;
  end

  // Read mux sees only current register state, so a read in a write cycle
  // returns the pre-write value everywhere.
  always_comb begin
    rd_val = '0;
    if (!is_io) begin
      rd_val = ram[daddr[ram_aw-1:0]];
    end else begin
      case (io_sel)
        IO_CYCLE:  rd_val = cycle;
        IO_TXDATA: rd_val = '0;
        IO_STATUS: rd_val = status_word;
        IO_INPORT: rd_val = in_port_r;
        default:   rd_val = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dQ        <= '0;
      cycle     <= '0;
      overflow  <= 1'b0;
      in_port_r <= '0;
    end else begin
      dQ        <= rd_val;
      in_port_r <= in_port;
      cycle     <= cyc_wr ? dD : cycle + 1'b1;
      // A new overflow takes priority over a clear in the same cycle.
      if (drop)
        overflow <= 1'b1;
      else if (st_wr && dD[ST_OVF])
        overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (dwrite && !is_io) ram[daddr[ram_aw-1:0]] <= dD;
  end

endmodule

// File: tb/tb_dbus_responder.sv
// Bench for dbus_responder: table of bus vectors with expected dQ, plus a
// queue-based scoreboard for the FIFO drain port and hand-written sequences.
module tb_dbus_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  daddr;
  logic        dwrite;
  logic [15:0] dD;
  logic [15:0] dQ;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] in_port;

  int tests = 0;
  int fails = 0;
  int occ   = 0;
  logic [15:0] exp_q[$];

  typedef struct {
    logic [7:0]  addr;
    logic        wr;
    logic [15:0] d;
    logic [15:0] inp;
    logic        rdy;
    logic        chk;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[$];

  dbus_responder #(
    .width          (16),
    .daddr_width    (8),
    .fifo_depth_log2(2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .daddr    (daddr),
    .dwrite   (dwrite),
    .dD       (dD),
    .dQ       (dQ),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .in_port  (in_port)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver / checker tasks
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] a, input logic w, input logic [15:0] d,
                              input logic [15:0] inp, input logic r, input logic c,
                              input logic [15:0] e);
    vec_t v;
    v.addr = a; v.wr = w; v.d = d; v.inp = inp; v.rdy = r; v.chk = c; v.exp = e;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    logic pop_now;
    logic accept;
    daddr = v.addr; dwrite = v.wr; dD = v.d; in_port = v.inp; out_ready = v.rdy;
    #0;
    check("out_valid", {15'b0, out_valid}, {15'b0, occ != 0});
    if (occ != 0 && exp_q.size() > 0) check("out_data", out_data, exp_q[0]);
    pop_now = (occ != 0) && v.rdy;
    accept  = v.wr && v.addr[7] && (v.addr[1:0] == 2'd1) && (occ < 4 || pop_now);
    if (pop_now && exp_q.size() > 0) void'(exp_q.pop_front());
    if (accept) exp_q.push_back(v.d);
    occ = occ + (accept ? 1 : 0) - (pop_now ? 1 : 0);
    @(posedge clk);
    #1;
    dwrite = 1'b0;
    if (v.chk) check($sformatf("dQ@%h", v.addr), dQ, v.exp);
  endtask

  initial begin
    reset = 1'b1; daddr = 8'h00; dwrite = 1'b0; dD = '0; out_ready = 1'b0; in_port = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_dQ", dQ, 16'h0000);
    check("reset_valid", {15'b0, out_valid}, 16'h0000);

    // counter counts edges since release
    reset = 1'b0;
    for (int i = 0; i <= 10; i++) apply(mk(8'h80, 0, 0, 0, 0, 1, 16'(i)));
    apply(mk(8'h80, 1, 16'hFFFE, 0, 0, 1, 16'd11));
    apply(mk(8'h80, 0, 0, 0, 0, 1, 16'hFFFE));
    apply(mk(8'h84, 0, 0, 0, 0, 1, 16'hFFFF));
    apply(mk(8'h80, 0, 0, 0, 0, 1, 16'h0000));
    apply(mk(8'hFC, 0, 0, 0, 0, 1, 16'h0001));

    // RAM
    vecs.push_back(mk(8'h05, 1, 16'h1234, 0, 0, 0, 0));
    vecs.push_back(mk(8'h05, 0, 0, 0, 0, 1, 16'h1234));
    vecs.push_back(mk(8'h05, 1, 16'hBEEF, 0, 0, 1, 16'h1234));
    vecs.push_back(mk(8'h05, 0, 0, 0, 0, 1, 16'hBEEF));
    vecs.push_back(mk(8'h7F, 1, 16'h0F0F, 0, 0, 0, 0));
    vecs.push_back(mk(8'h7F, 0, 0, 0, 0, 1, 16'h0F0F));
    vecs.push_back(mk(8'h05, 0, 0, 0, 0, 1, 16'hBEEF));
    // FIFO fill and overflow
    vecs.push_back(mk(8'h82, 0, 0, 0, 0, 1, 16'h0002));
    vecs.push_back(mk(8'h81, 1, 16'h00A0, 0, 0, 1, 16'h0000));
    vecs.push_back(mk(8'h81, 1, 16'h00A1, 0, 0, 1, 16'h0000));
    vecs.push_back(mk(8'h81, 1, 16'h00A2, 0, 0, 1, 16'h0000));
    vecs.push_back(mk(8'h81, 1, 16'h00A3, 0, 0, 1, 16'h0000));
    vecs.push_back(mk(8'h82, 0, 0, 0, 0, 1, 16'h0001));
    vecs.push_back(mk(8'h81, 1, 16'h00A4, 0, 0, 1, 16'h0000));
    vecs.push_back(mk(8'h82, 0, 0, 0, 0, 1, 16'h0005));
    vecs.push_back(mk(8'h86, 1, 16'h0004, 0, 0, 1, 16'h0005));
    vecs.push_back(mk(8'h82, 0, 0, 0, 0, 1, 16'h0001));
    vecs.push_back(mk(8'h81, 1, 16'h00A5, 0, 0, 1, 16'h0000));
    vecs.push_back(mk(8'h82, 0, 0, 0, 0, 1, 16'h0005));
    // push while full with pop, then clear and drain
    vecs.push_back(mk(8'h81, 1, 16'h00B0, 0, 1, 1, 16'h0000));
    vecs.push_back(mk(8'h82, 0, 0, 0, 0, 1, 16'h0005));
    vecs.push_back(mk(8'h82, 1, 16'h0004, 0, 0, 1, 16'h0005));
    vecs.push_back(mk(8'h82, 0, 0, 0, 1, 1, 16'h0001));
    vecs.push_back(mk(8'h82, 0, 0, 0, 1, 1, 16'h0000));
    vecs.push_back(mk(8'h81, 1, 16'h00C0, 0, 1, 1, 16'h0000));
    vecs.push_back(mk(8'h82, 0, 0, 0, 1, 1, 16'h0000));
    vecs.push_back(mk(8'h82, 0, 0, 0, 1, 1, 16'h0000));
    vecs.push_back(mk(8'h82, 0, 0, 0, 1, 1, 16'h0002));
    vecs.push_back(mk(8'h81, 1, 16'h00D5, 0, 1, 1, 16'h0000));
    vecs.push_back(mk(8'h82, 0, 0, 0, 1, 1, 16'h0000));
    vecs.push_back(mk(8'h82, 0, 0, 0, 0, 1, 16'h0002));
    // INPORT
    vecs.push_back(mk(8'h83, 0, 0, 16'h5A5A, 0, 1, 16'h0000));
    vecs.push_back(mk(8'h83, 0, 0, 16'h5A5A, 0, 1, 16'h5A5A));
    vecs.push_back(mk(8'hFF, 0, 0, 16'h5A5A, 0, 1, 16'h5A5A));
    vecs.push_back(mk(8'h83, 1, 16'h1111, 16'h5A5A, 0, 1, 16'h5A5A));
    vecs.push_back(mk(8'h83, 0, 0, 16'h1234, 0, 1, 16'h5A5A));
    vecs.push_back(mk(8'hFF, 0, 0, 16'h1234, 0, 1, 16'h1234));

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);
    check("sb_drained", 16'(exp_q.size()), 16'h0000);

    // reset with entries queued and the consumer ready
    apply(mk(8'h81, 1, 16'h00E0, 16'h1234, 0, 1, 16'h0000));
    apply(mk(8'h81, 1, 16'h00E1, 16'h1234, 0, 1, 16'h0000));
    apply(mk(8'h81, 1, 16'h00E2, 16'h1234, 0, 1, 16'h0000));
    reset = 1'b1; daddr = 8'h83; out_ready = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    occ = 0;
    check("rst_mid_valid", {15'b0, out_valid}, 16'h0000);
    check("rst_mid_dQ", dQ, 16'h0000);
    apply(mk(8'h82, 0, 0, 16'h1234, 1, 1, 16'h0002));
    apply(mk(8'h80, 0, 0, 16'h1234, 0, 1, 16'h0001));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
